// File: rtl/bbox_pkg.sv
// bbox_pkg: shared state encoding, default widths and result box type for the bounding-box scheduler
package bbox_pkg;
  localparam int DEF_ADDR_W = 15;
  localparam int DEF_DATA_W = 16;
  localparam int DEF_COORD_W = 11;
  typedef enum logic [2:0] {IDLE, FILL, START, RUN, PUBLISH} sched_state_t;
  typedef struct packed {
    logic [DEF_COORD_W-1:0] xmin;
    logic [DEF_COORD_W-1:0] xmax;
    logic [DEF_COORD_W-1:0] ymin;
    logic [DEF_COORD_W-1:0] ymax;
  } bbox_t;
endpackage

// File: rtl/bbox_watchdog.sv
// bbox_watchdog: run-cycle counter that flags the last allowed cycle; TIMEOUT of 0 never expires
module bbox_watchdog #(
  parameter int TIMEOUT = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);
  localparam int CW = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST = CW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
  logic [CW-1:0] cnt_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else if (clr_i) cnt_q <= '0;
    else if (en_i) cnt_q <= cnt_q + CW'(1);
  assign expired_o = (TIMEOUT != 0) && en_i && (cnt_q == LAST);
endmodule

// File: rtl/bbox_frame_scheduler.sv
// bbox_frame_scheduler: runs fill/start/run/publish per frame and muxes the single image RAM port
module bbox_frame_scheduler
  import bbox_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int COORD_W = DEF_COORD_W,
  parameter int TIMEOUT = 1000000,
  parameter int FID_W   = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable_i,
  input  logic               wr_req_i,
  input  logic [ADDR_W-1:0]  wr_addr_i,
  input  logic [DATA_W-1:0]  wr_data_i,
  output logic               wr_gnt_o,
  input  logic               frame_wr_done_i,
  output logic               bb_start_o,
  input  logic               bb_done_i,
  input  logic [31:0]        bb_addr_i,
  output logic [DATA_W-1:0]  bb_rddata_o,
  input  logic [COORD_W-1:0] bb_xmin_i,
  input  logic [COORD_W-1:0] bb_xmax_i,
  input  logic [COORD_W-1:0] bb_ymin_i,
  input  logic [COORD_W-1:0] bb_ymax_i,
  output logic [ADDR_W-1:0]  ram_addr_o,
  output logic [DATA_W-1:0]  ram_wrdata_o,
  output logic               ram_we_o,
  input  logic [DATA_W-1:0]  ram_rddata_i,
  output logic               res_valid_o,
  input  logic               res_ready_i,
  output logic [COORD_W-1:0] res_xmin_o,
  output logic [COORD_W-1:0] res_xmax_o,
  output logic [COORD_W-1:0] res_ymin_o,
  output logic [COORD_W-1:0] res_ymax_o,
  output logic               res_err_o,
  output logic [FID_W-1:0]   res_fid_o,
  output logic               ovr_err_o,
  output logic               busy_o
);
  sched_state_t state_q;
  bbox_t res_q, box_d;
  logic res_err_q, ovr_err_q, expired;
  logic [FID_W-1:0] res_fid_q;
  assign box_d = '{xmin: DEF_COORD_W'(bb_xmin_i), xmax: DEF_COORD_W'(bb_xmax_i),
                   ymin: DEF_COORD_W'(bb_ymin_i), ymax: DEF_COORD_W'(bb_ymax_i)};
  bbox_watchdog #(.TIMEOUT(TIMEOUT)) u_wd (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_i    (state_q == START),
    .en_i     (state_q == RUN),
    .expired_o(expired)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q   <= IDLE;
      res_q     <= '0;
      res_err_q <= 1'b0;
      res_fid_q <= '0;
      ovr_err_q <= 1'b0;
    end else begin
      if (frame_wr_done_i && state_q != FILL) ovr_err_q <= 1'b1;
      case (state_q)
        IDLE:    if (enable_i) state_q <= FILL;
        FILL:    if (frame_wr_done_i) state_q <= START;
        START:   state_q <= RUN;
        RUN:     if (bb_done_i || expired) begin
                   res_q     <= bb_done_i ? box_d : '0;
                   res_err_q <= !bb_done_i;
                   state_q   <= PUBLISH;
                 end
        PUBLISH: if (res_ready_i) begin
                   res_fid_q <= res_fid_q + 1'b1;
                   state_q   <= enable_i ? FILL : IDLE;
                 end
        default: state_q <= IDLE;
      endcase
    end
  // Port ownership is decoded straight from state so the writer sees its grant the same cycle
  assign wr_gnt_o     = state_q == FILL;
  assign ram_we_o     = wr_gnt_o && wr_req_i;
  assign ram_wrdata_o = wr_gnt_o ? wr_data_i : '0;
  assign ram_addr_o   = wr_gnt_o ? wr_addr_i : (state_q == RUN) ? bb_addr_i[ADDR_W-1:0] : '0;
  assign bb_rddata_o  = ram_rddata_i;
  assign bb_start_o   = state_q == START;
  assign res_valid_o  = state_q == PUBLISH;
  assign res_xmin_o   = COORD_W'(res_q.xmin);
  assign res_xmax_o   = COORD_W'(res_q.xmax);
  assign res_ymin_o   = COORD_W'(res_q.ymin);
  assign res_ymax_o   = COORD_W'(res_q.ymax);
  assign res_err_o    = res_err_q;
  assign res_fid_o    = res_fid_q;
  assign ovr_err_o    = ovr_err_q;
  assign busy_o       = state_q != IDLE;
endmodule
